// File: rtl/serial_deframer.sv
// serial_deframer: receive-side deframer for a retimed, idle-high serial line.
// Frame = low start bit, WIDTH data bits (LSB first), one parity bit, high stop bit.
// A good frame updates dout/par_err with a one-clk dout_valid strobe.
// A bad stop bit gives a one-clk frame_err strobe and then waits for the line to go high.
module serial_deframer #(
    parameter int WIDTH       = 8,
    parameter bit PARITY_EVEN = 1'b1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             din,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             par_err,
    output logic             frame_err,
    output logic             busy
);

    // Bit counter width; it only has to reach WIDTH-1.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic [WIDTH-1:0] shreg_reg, shreg_next;
    logic             acc_reg, acc_next;
    logic [WIDTH-1:0] dout_reg, dout_next;
    logic             par_err_reg, par_err_next;
    logic             dout_valid_reg, dout_valid_next;
    logic             frame_err_reg, frame_err_next;

    // Shift register with the new bit entering at the MSB side, so that after
    // WIDTH data bits the first bit on the line sits in bit 0.
    logic [WIDTH-1:0] shreg_shifted;
    assign shreg_shifted[WIDTH-1] = din;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH - 1; gi = gi + 1) begin : g_shift
            assign shreg_shifted[gi] = shreg_reg[gi+1];
        end
    endgenerate

    // State register; a reset at any time abandons a partial frame.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; nothing advances on edges where en is low.
    always_comb begin
        state_next = state_reg;
        if (en) begin
            case (state_reg)
                S_IDLE: begin
                    if (!din) begin
                        state_next = S_DATA;
                    end
                end
                S_DATA: begin
                    if (cnt_reg == LAST_BIT) begin
                        state_next = S_PARITY;
                    end
                end
                S_PARITY: begin
                    state_next = S_STOP;
                end
                S_STOP: begin
                    state_next = din ? S_IDLE : S_WAIT_HIGH;
                end
                S_WAIT_HIGH: begin
                    // A low line here is the tail of a broken frame, never a start bit.
                    if (din) begin
                        state_next = S_IDLE;
                    end
                end
                default: begin
                    state_next = S_IDLE;
                end
            endcase
        end
    end

    // Datapath and output next values. The strobes default to 0, so they last
    // exactly one clk whether or not en is high on the following edge.
    always_comb begin
        cnt_next        = cnt_reg;
        shreg_next      = shreg_reg;
        acc_next        = acc_reg;
        dout_next       = dout_reg;
        par_err_next    = par_err_reg;
        dout_valid_next = 1'b0;
        frame_err_next  = 1'b0;
        if (en) begin
            case (state_reg)
                S_IDLE: begin
                    if (!din) begin
                        cnt_next = '0;
                        acc_next = 1'b0;
                    end
                end
                S_DATA: begin
                    shreg_next = shreg_shifted;
                    acc_next   = acc_reg ^ din;
                    cnt_next   = cnt_reg + CW'(1);
                end
                S_PARITY: begin
                    acc_next = acc_reg ^ din;
                end
                S_STOP: begin
                    if (din) begin
                        // Data and parity XOR to 0 for even parity and to 1 for odd.
                        // An accumulator equal to PARITY_EVEN is therefore the wrong value.
                        dout_next       = shreg_reg;
                        par_err_next    = (acc_reg == PARITY_EVEN);
                        dout_valid_next = 1'b1;
                    end else begin
                        frame_err_next = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_reg        <= '0;
            shreg_reg      <= '0;
            acc_reg        <= 1'b0;
            dout_reg       <= '0;
            par_err_reg    <= 1'b0;
            dout_valid_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
        end else begin
            cnt_reg        <= cnt_next;
            shreg_reg      <= shreg_next;
            acc_reg        <= acc_next;
            dout_reg       <= dout_next;
            par_err_reg    <= par_err_next;
            dout_valid_reg <= dout_valid_next;
            frame_err_reg  <= frame_err_next;
        end
    end

    // Outputs: busy comes straight from the state register.
    always_comb begin
        dout       = dout_reg;
        par_err    = par_err_reg;
        dout_valid = dout_valid_reg;
        frame_err  = frame_err_reg;
        busy       = (state_reg != S_IDLE);
    end

endmodule

// File: tb/tb_serial_deframer.sv
// Testbench for serial_deframer (WIDTH=8, even parity).
// The driver pushes hand-computed expected words into a scoreboard queue.
// A monitor running on the falling edge pops and compares on every dout_valid.
module tb_serial_deframer;

    localparam int WIDTH = 8;

    logic             clk  = 1'b0;
    logic             rstn = 1'b1;
    logic             en   = 1'b0;
    logic             din  = 1'b1;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             par_err;
    logic             frame_err;
    logic             busy;

    serial_deframer #(
        .WIDTH(WIDTH),
        .PARITY_EVEN(1'b1)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .en(en),
        .din(din),
        .dout(dout),
        .dout_valid(dout_valid),
        .par_err(par_err),
        .frame_err(frame_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int         checks     = 0;
    int         errors     = 0;
    int         cyc        = 0;
    int         n_valid    = 0;
    int         n_ferr     = 0;
    int         fe_pending = 0;
    logic [8:0] exp_q[$];      // {data, expected par_err}
    int         valid_cyc[$];
    logic       prev_valid = 1'b0;
    logic       prev_ferr  = 1'b0;
    logic [8:0] mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compares every strobe against the scoreboard and checks pulse widths.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (dout_valid) begin
                n_valid++;
                valid_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: got dout=%0h with nothing expected", dout);
                end else begin
                    mon_e = exp_q.pop_front();
                    $display("word dout=%02h par_err=%b (expected %02h/%b) cycle %0d",
                             dout, par_err, mon_e[8:1], mon_e[0], cyc);
                    chk("sb_dout", 32'(dout), 32'(mon_e[8:1]));
                    chk("sb_par_err", 32'(par_err), 32'(mon_e[0]));
                end
                chk("valid_width", 32'(prev_valid), 32'd0);
            end
            if (frame_err) begin
                n_ferr++;
                $display("frame_err strobe cycle %0d", cyc);
                if (fe_pending == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame_err: got 1 expected 0");
                end else begin
                    fe_pending--;
                end
                chk("ferr_width", 32'(prev_ferr), 32'd0);
                chk("ferr_no_valid", 32'(dout_valid), 32'd0);
            end
            prev_valid = dout_valid;
            prev_ferr  = frame_err;
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One enabled bit, then gap cycles with en low and din random.
    task automatic send_bit(input logic b, input int gap);
        @(negedge clk);
        en  = 1'b1;
        din = b;
        for (int i = 0; i < gap; i++) begin
            @(negedge clk);
            en  = 1'b0;
            din = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stop,
                              input logic exp_perr, input int gap);
        if (stop) exp_q.push_back({d, exp_perr});
        else fe_pending++;
        send_bit(1'b0, gap);
        for (int i = 0; i < 8; i++) send_bit(d[i], gap);
        send_bit(pbit, gap);
        send_bit(stop, gap);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            en  = 1'b1;
            din = 1'b1;
        end
    endtask

    // Bounded wait for all expected strobes to arrive.
    task automatic wait_drain();
        int k = 0;
        while ((exp_q.size() != 0 || fe_pending != 0) && k < 40) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("drain", 32'(exp_q.size() + fe_pending), 32'd0);
    endtask

    int nv;
    int base;

    initial begin
        // Asynchronous reset before any clock edge.
        #1 rstn = 1'b0;
        #2;
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_valid", 32'(dout_valid), 32'd0);
        chk("rst_par_err", 32'(par_err), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        idle(2);

        // Good frame 0xA5, 4 ones -> parity bit 0.
        send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 0);
        idle(2);
        wait_drain();

        // Parity error on 0xA5, then good 0x3C clears par_err.
        send_frame(8'hA5, 1'b1, 1'b1, 1'b1, 0);
        idle(2);
        send_frame(8'h3C, 1'b0, 1'b1, 1'b0, 0);
        idle(2);
        wait_drain();
        chk("after_3c_dout", 32'(dout), 32'h3C);

        // Framing error on 0x5A, line held low for 5 cycles, then high.
        nv = n_valid;
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            en  = 1'b1;
            din = 1'b0;
            chk("wait_high_busy", 32'(busy), 32'd1);
        end
        @(negedge clk);
        din = 1'b1;
        @(negedge clk);
        chk("wait_high_exit_busy", 32'(busy), 32'd0);
        chk("ferr_no_new_valid", 32'(n_valid - nv), 32'd0);
        chk("ferr_dout_kept", 32'(dout), 32'h3C);
        chk("ferr_count", 32'(n_ferr), 32'd1);
        send_frame(8'h81, 1'b0, 1'b1, 1'b0, 0);
        idle(2);
        wait_drain();

        // en gaps of 3 cycles after every bit with random din.
        nv = n_valid;
        send_frame(8'hC3, 1'b0, 1'b1, 1'b0, 3);
        idle(3);
        wait_drain();
        chk("gap_valid_count", 32'(n_valid - nv), 32'd1);
        chk("gap_dout", 32'(dout), 32'hC3);

        // Reset dropped between edges after 4 data bits of a 0x66 frame.
        nv = n_valid;
        send_bit(1'b0, 0);
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        @(posedge clk);
        #3 rstn = 1'b0;
        #1;
        chk("midrst_dout", 32'(dout), 32'd0);
        chk("midrst_valid", 32'(dout_valid), 32'd0);
        chk("midrst_par_err", 32'(par_err), 32'd0);
        chk("midrst_frame_err", 32'(frame_err), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        din = 1'b1;
        @(negedge clk);
        rstn = 1'b1;
        idle(2);
        chk("midrst_no_strobe", 32'(n_valid - nv), 32'd0);
        send_frame(8'h7E, 1'b0, 1'b1, 1'b0, 0);
        idle(2);
        wait_drain();
        chk("after_rst_dout", 32'(dout), 32'h7E);

        // Back-to-back frames with no idle bits: 0x01 (parity 1), 0xFF, 0x00.
        base = valid_cyc.size();
        send_frame(8'h01, 1'b1, 1'b1, 1'b0, 0);
        send_frame(8'hFF, 1'b0, 1'b1, 1'b0, 0);
        send_frame(8'h00, 1'b0, 1'b1, 1'b0, 0);
        idle(3);
        wait_drain();
        chk("b2b_count", 32'(valid_cyc.size() - base), 32'd3);
        if (valid_cyc.size() >= base + 3) begin
            chk("b2b_space1", 32'(valid_cyc[base+1] - valid_cyc[base]), 32'd11);
            chk("b2b_space2", 32'(valid_cyc[base+2] - valid_cyc[base+1]), 32'd11);
        end
        chk("final_busy", 32'(busy), 32'd0);
        chk("final_ferr_total", 32'(n_ferr), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
